capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Capture-unit controller of the logic analyzer. Decimates the channel sample strobe and
//  drives write enable/address into the five RAMqueue channel buffers (circular).
//  Arms once enough pre-trigger history is held, takes post-trigger samples, then pulses
//  set_capture_done into cmd_cfg. On done, waddr points at the oldest sample, where cmd_cfg starts readout.
// PARAMETERS
//  ENTRIES  384  depth of each RAMqueue (samples per channel)
//  LOG2     9    width of waddr/trig_pos/counters (ceil(log2(ENTRIES)))
// PORTS
//  clk               in   1     system clock, all state on posedge
//  rst_n             in   1     asynchronous active-low reset
//  run               in   1     capture enable from cmd_cfg TrigCfg; level
//  wrt_smpl          in   1     one-cycle raw sample strobe from channel samplers
//  triggered         in   1     trigger-logic output; level, sampled each clk
//  decimator         in   4     keep 1 of every 2^decimator strobes
//  trig_pos          in   LOG2  number of samples to store after trigger
//  we                out  1     RAM write enable (common to all channels)
//  waddr             out  LOG2  RAM write address; also readout start pointer to cmd_cfg
//  armed             out  1     pre-trigger history sufficient; trigger is honoured
//  capturing         out  1     state is CAPTURE or POSTTRIG
//  set_capture_done  out  1     one-cycle pulse on capture completion
// BEHAVIOUR
//  Reset: state=IDLE; waddr, dec_cnt, smpl_cnt, trig_cnt = 0; we, armed, capturing, set_capture_done = 0.
//  tp = min(trig_pos, ENTRIES-1) (clamped).
//  accept = wrt_smpl && (dec_cnt == 2^decimator-1) && state in {CAPTURE,POSTTRIG}.
//  dec_cnt (16b): +1 on every wrt_smpl in CAPTURE/POSTTRIG; cleared on accept and on IDLE->CAPTURE.
//  we = accept (combinational from registered state + wrt_smpl); RAMs write at current waddr.
//  waddr: +1 on the clk after each accept; ENTRIES-1 wraps to 0. Held in IDLE and DONE.
//  States:
//   IDLE: run=1 -> CAPTURE; waddr, dec_cnt, smpl_cnt, trig_cnt, armed cleared on the transition.
//   CAPTURE: smpl_cnt +1 per accept, saturates at ENTRIES.
//     armed (registered) = (smpl_cnt + tp >= ENTRIES), computed LOG2+1 bits wide.
//     triggered && armed: tp==0 -> DONE, else -> POSTTRIG (trig_cnt=0).
//     triggered && !armed: ignored. Accept in the transition cycle counts as pre-trigger.
//   POSTTRIG: trig_cnt +1 per accept; accept making trig_cnt==tp -> DONE next clk.
//     triggered ignored here.
//   DONE: set_capture_done=1 for exactly the entry cycle; we=0; waddr frozen.
//     run=0 -> IDLE. run staying 1 never restarts capture.
//  run=0 in CAPTURE/POSTTRIG -> IDLE next clk, no done pulse, waddr held, armed cleared.
//  Async reset in any state returns all outputs to reset values immediately.
//  decimator changes during capture take effect on the next compare; dec_cnt is not cleared.
// TESTING
//  T1 dec=0, trig_pos=10, run=1, wrt_smpl every clk, triggered=0: armed rises after 374 accepts.
//     Then wrt_smpl=0 for one clk with triggered=1, resume strobes -> exactly 10 more we,
//     set_capture_done 1-clk pulse, total 384 writes, waddr==0, capturing=0.
//  T2 dec=2, wrt_smpl every clk -> we on 4th,8th,12th strobe; waddr increments 0,1,2.
//  T3 triggered=1 from run start, trig_pos=200 -> no transition before armed (184 accepts);
//     POSTTRIG entered on first armed clk; done after 200 post writes.
//  T4 run dropped after 50 accepts -> IDLE next clk, no done pulse, no further we, waddr==50.
//  T5 trig_pos=0 -> armed after 384 accepts (waddr wrapped to 0).
//     Trigger -> DONE next clk, zero post writes, done pulse once.
//     run kept 1 for 20 clks -> no restart; run=0 -> IDLE.
//  T6 async rst_n low mid-POSTTRIG -> all outputs 0 within same cycle; clean capture after release.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// Capture controller bus: control inputs from cmd_cfg / samplers / trigger
// logic, and RAM write + status outputs from the controller.
// Handshake: wrt_smpl is a one-cycle strobe with no back-pressure; the
// controller never stalls it. we is asserted in the same cycle as the
// strobe it accepts, and the RAMs write at the waddr presented that cycle.
interface capture_ctrl_if #(
    parameter int LOG2 = 9
);
    logic            run;
    logic            wrt_smpl;
    logic            triggered;
    logic [3:0]      decimator;
    logic [LOG2-1:0] trig_pos;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            armed;
    logic            capturing;
    logic            set_capture_done;
    logic [1:0]      state_dbg;

    modport master (
        output run, wrt_smpl, triggered, decimator, trig_pos,
        input  we, waddr, armed, capturing, set_capture_done, state_dbg
    );

    modport slave (
        input  run, wrt_smpl, triggered, decimator, trig_pos,
        output we, waddr, armed, capturing, set_capture_done, state_dbg
    );
endinterface

// File: rtl/capture_ctrl.sv
// Logic-analyzer capture controller: decimates the sample strobe, writes the
// circular channel RAMs, arms once enough pre-trigger history is held, takes
// the post-trigger samples and pulses set_capture_done. On completion waddr
// points at the oldest stored sample, which is where readout begins.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input logic           clk,
    input logic           rst_n,
    capture_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_POSTTRIG = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [LOG2-1:0] LAST   = LOG2'(ENTRIES - 1);
    localparam logic [LOG2-1:0] FULL   = LOG2'(ENTRIES);
    localparam logic [LOG2:0]   FULL_W = (LOG2 + 1)'(ENTRIES);

    state_t          state_q;
    logic [15:0]     dec_cnt_q;
    logic [LOG2-1:0] waddr_q;
    logic [LOG2-1:0] smpl_cnt_q;
    logic [LOG2-1:0] trig_cnt_q;
    logic            armed_q;
    logic            capturing_q;
    logic            done_q;

    logic            active;
    logic [15:0]     dec_limit;
    logic            accept;
    logic [LOG2-1:0] tp;
    logic [LOG2-1:0] waddr_inc;
    logic [LOG2-1:0] smpl_nxt;
    logic [LOG2-1:0] trig_nxt;
    logic            arm_nxt;

    // Accept decision, clamped trigger position and next counter values
    always_comb begin
        active    = (state_q == S_CAPTURE) || (state_q == S_POSTTRIG);
        dec_limit = (16'd1 << bus.decimator) - 16'd1;
        accept    = active && bus.wrt_smpl && (dec_cnt_q == dec_limit);
        // A post-trigger count of ENTRIES or more would overwrite the trigger point
        tp        = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
        waddr_inc = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;
        smpl_nxt  = smpl_cnt_q;
        if (accept && (smpl_cnt_q != FULL)) begin
            smpl_nxt = smpl_cnt_q + 1'b1;
        end
        trig_nxt  = trig_cnt_q + 1'b1;
        // Armed once the history already held plus the samples still to come fill the RAM
        arm_nxt   = ({1'b0, smpl_nxt} + {1'b0, tp}) >= FULL_W;
    end

    // Capture FSM with registered status outputs and sample counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dec_cnt_q   <= '0;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            trig_cnt_q  <= '0;
            armed_q     <= 1'b0;
            capturing_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active && bus.wrt_smpl) begin
                dec_cnt_q <= accept ? '0 : dec_cnt_q + 16'd1;
            end
            if (accept) begin
                waddr_q <= waddr_inc;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q     <= S_CAPTURE;
                        dec_cnt_q   <= '0;
                        waddr_q     <= '0;
                        smpl_cnt_q  <= '0;
                        trig_cnt_q  <= '0;
                        armed_q     <= 1'b0;
                        capturing_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (!bus.run) begin
                        state_q     <= S_IDLE;
                        armed_q     <= 1'b0;
                        capturing_q <= 1'b0;
                    end else begin
                        // A sample accepted in the trigger cycle still counts as history
                        smpl_cnt_q <= smpl_nxt;
                        armed_q    <= arm_nxt;
                        if (bus.triggered && armed_q) begin
                            if (tp == '0) begin
                                state_q     <= S_DONE;
                                capturing_q <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                state_q    <= S_POSTTRIG;
                                trig_cnt_q <= '0;
                            end
                        end
                    end
                end
                S_POSTTRIG: begin
                    if (!bus.run) begin
                        state_q     <= S_IDLE;
                        armed_q     <= 1'b0;
                        capturing_q <= 1'b0;
                    end else if (accept) begin
                        trig_cnt_q <= trig_nxt;
                        if (trig_nxt >= tp) begin
                            state_q     <= S_DONE;
                            capturing_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Holding run high never restarts; cmd_cfg must drop it first
                    if (!bus.run) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.we               = accept;
    assign bus.waddr            = waddr_q;
    assign bus.armed            = armed_q;
    assign bus.capturing        = capturing_q;
    assign bus.set_capture_done = done_q;
    assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: a decimation vector table, directed multi-cycle
// scenarios, and a long randomized run against a sample-counting model.
module tb_capture_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capture_ctrl_if #(.LOG2(LOG2)) bus ();

    capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: capture progress expressed as sample counts
    bit m_cap, m_post, m_done, m_arm, m_pulse;
    int m_strobes, m_pre, m_post_n, m_waddr;

    typedef struct {
        bit run;
        bit wrt;
        bit trig;
        bit exp_we;
        int exp_waddr;
        bit exp_cap;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_tp(input int tpi);
        return (tpi > ENTRIES - 1) ? ENTRIES - 1 : tpi;
    endfunction

    task automatic model_reset();
        m_cap = 0; m_post = 0; m_done = 0; m_arm = 0; m_pulse = 0;
        m_strobes = 0; m_pre = 0; m_post_n = 0; m_waddr = 0;
    endtask

    // One clock: drive at negedge, check we before the edge, check registers after it
    task automatic step(input bit run, input bit wrt, input bit trig, output bit we_s, output bit done_s);
        int  period;
        int  tp;
        bit  acc;
        bit  arm_old;
        @(negedge clk);
        bus.run       = run;
        bus.wrt_smpl  = wrt;
        bus.triggered = trig;
        #1;
        period = 1 << bus.decimator;
        tp     = clamp_tp(int'(bus.trig_pos));
        acc    = m_cap && wrt && (((m_strobes + 1) % period) == 0);
        check("we", bus.we, acc);
        we_s = bus.we;
        @(posedge clk);
        arm_old = m_arm;
        m_pulse = 0;
        if (m_cap && wrt) m_strobes++;
        if (acc) m_waddr = (m_waddr + 1) % ENTRIES;
        if (!m_cap && !m_done) begin
            if (run) begin
                m_cap = 1; m_post = 0; m_strobes = 0; m_pre = 0;
                m_post_n = 0; m_waddr = 0; m_arm = 0;
            end
        end else if (m_done) begin
            if (!run) m_done = 0;
        end else if (!run) begin
            m_cap = 0; m_arm = 0;
        end else if (!m_post) begin
            if (acc && m_pre < ENTRIES) m_pre++;
            m_arm = (m_pre + tp) >= ENTRIES;
            if (trig && arm_old) begin
                if (tp == 0) begin
                    m_cap = 0; m_done = 1; m_pulse = 1;
                end else begin
                    m_post = 1; m_post_n = 0;
                end
            end
        end else if (acc) begin
            m_post_n++;
            if (m_post_n >= tp) begin
                m_cap = 0; m_post = 0; m_done = 1; m_pulse = 1;
            end
        end
        #1;
        check("waddr", bus.waddr, m_waddr);
        check("armed", bus.armed, m_arm);
        check("capturing", bus.capturing, m_cap);
        check("done", bus.set_capture_done, m_pulse);
        done_s = bus.set_capture_done;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.wrt_smpl  = 1'b0;
        bus.triggered = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe every cycle until armed; returns accepted-sample count
    task automatic fill_to_armed(input bit trig, output int acc);
        bit w, d;
        int n;
        acc = 0;
        n   = 0;
        while (!bus.armed && n < 2000) begin
            step(1, 1, trig, w, d);
            acc += w;
            n++;
        end
        check("armed_reached", bus.armed, 1);
    endtask

    // Strobe every cycle until the done pulse; returns accepted-sample count
    task automatic run_to_done(input bit trig, output int acc, output bit seen);
        bit w, d;
        int n;
        acc  = 0;
        seen = 0;
        n    = 0;
        while (!seen && n < 2000) begin
            step(1, 1, trig, w, d);
            acc  += w;
            seen |= d;
            n++;
        end
    endtask

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bit w, d, seen;
        int acc, post, cnt, wsum, dsum, csum;

        bus.run       = 1'b0;
        bus.wrt_smpl  = 1'b0;
        bus.triggered = 1'b0;
        bus.decimator = 4'd0;
        bus.trig_pos  = '0;
        model_reset();

        // decimator=2: every 4th strobe is written, addresses 0,1,2
        tbl[0]  = '{1, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 0, 1, 1, 1};
        tbl[5]  = '{1, 1, 0, 0, 1, 1};
        tbl[6]  = '{1, 1, 0, 0, 1, 1};
        tbl[7]  = '{1, 1, 0, 0, 1, 1};
        tbl[8]  = '{1, 1, 0, 1, 2, 1};
        tbl[9]  = '{1, 1, 0, 0, 2, 1};
        tbl[10] = '{1, 1, 0, 0, 2, 1};
        tbl[11] = '{1, 1, 0, 0, 2, 1};
        tbl[12] = '{1, 1, 0, 1, 3, 1};
        tbl[13] = '{0, 0, 0, 0, 3, 0};

        // Reset values while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.waddr, 0);
        check("rst_armed", bus.armed, 0);
        check("rst_capturing", bus.capturing, 0);
        check("rst_done", bus.set_capture_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2 table: decimation
        bus.decimator = 4'd2;
        bus.trig_pos  = 9'd10;
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].run, tbl[i].wrt, tbl[i].trig, w, d);
            check("tbl_we", w, tbl[i].exp_we);
            check("tbl_waddr", bus.waddr, tbl[i].exp_waddr);
            check("tbl_capturing", bus.capturing, tbl[i].exp_cap);
        end

        // T1: trig_pos=10, full capture, waddr ends at oldest sample
        do_reset();
        bus.decimator = 4'd0;
        bus.trig_pos  = 9'd10;
        step(1, 0, 0, w, d);
        fill_to_armed(0, acc);
        check("t1_pre_accepts", acc, 374);
        step(1, 0, 1, w, d);
        run_to_done(0, post, seen);
        check("t1_done_seen", seen, 1);
        check("t1_post_writes", post, 10);
        check("t1_total_writes", acc + post, 384);
        check("t1_waddr", bus.waddr, 0);
        check("t1_capturing", bus.capturing, 0);
        step(1, 1, 0, w, d);
        check("t1_single_pulse", d, 0);
        check("t1_no_we_done", w, 0);
        step(0, 0, 0, w, d);

        // T3: trigger held from start is ignored until armed
        do_reset();
        bus.trig_pos = 9'd200;
        step(1, 0, 1, w, d);
        fill_to_armed(1, acc);
        check("t3_pre_accepts", acc, 184);
        run_to_done(1, post, seen);
        check("t3_done_seen", seen, 1);
        check("t3_writes_after_arm", post, 201);
        check("t3_waddr", bus.waddr, 1);
        step(0, 0, 0, w, d);

        // T4: run dropped mid-capture
        do_reset();
        bus.trig_pos = 9'd10;
        step(1, 0, 0, w, d);
        repeat (50) step(1, 1, 0, w, d);
        check("t4_waddr_50", bus.waddr, 50);
        step(0, 0, 0, w, d);
        check("t4_idle", bus.capturing, 0);
        check("t4_no_done", d, 0);
        check("t4_armed", bus.armed, 0);
        wsum = 0;
        repeat (3) begin
            step(0, 1, 0, w, d);
            wsum += w;
        end
        check("t4_no_we", wsum, 0);
        check("t4_waddr_held", bus.waddr, 50);

        // T5: trig_pos=0 needs a full RAM, then done without post writes
        do_reset();
        bus.trig_pos = 9'd0;
        step(1, 0, 0, w, d);
        fill_to_armed(0, acc);
        check("t5_pre_accepts", acc, 384);
        check("t5_waddr_wrap", bus.waddr, 0);
        step(1, 0, 1, w, d);
        check("t5_done", d, 1);
        wsum = 0; dsum = 0; csum = 0;
        repeat (20) begin
            step(1, 1, 1, w, d);
            wsum += w; dsum += d; csum += bus.capturing;
        end
        check("t5_no_restart_we", wsum, 0);
        check("t5_no_extra_done", dsum, 0);
        check("t5_no_restart_cap", csum, 0);
        check("t5_waddr", bus.waddr, 0);
        step(0, 0, 0, w, d);
        step(1, 0, 0, w, d);
        check("t5_restart_after_idle", bus.capturing, 1);

        // T6: asynchronous reset during post-trigger
        do_reset();
        bus.trig_pos = 9'd50;
        step(1, 0, 0, w, d);
        fill_to_armed(0, acc);
        step(1, 0, 1, w, d);
        repeat (5) step(1, 1, 0, w, d);
        bus.wrt_smpl = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_we", bus.we, 0);
        check("t6_waddr", bus.waddr, 0);
        check("t6_armed", bus.armed, 0);
        check("t6_capturing", bus.capturing, 0);
        check("t6_done", bus.set_capture_done, 0);
        bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.triggered = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.decimator = 4'd1;
        bus.trig_pos  = 9'd3;
        step(1, 0, 0, w, d);
        fill_to_armed(0, acc);
        check("t6_pre_accepts", acc, 381);
        step(1, 0, 1, w, d);
        run_to_done(0, post, seen);
        check("t6_clean_done", seen, 1);
        check("t6_clean_post", post, 3);
        step(0, 0, 0, w, d);

        // Randomized run against the model
        do_reset();
        cnt = 0;
        for (int i = 0; i < 24000; i++) begin
            bit r, s, t;
            if (!m_cap && !m_done) begin
                bus.decimator = 4'($urandom_range(0, 2));
                bus.trig_pos  = 9'($urandom_range(0, 511));
                r = ($urandom_range(0, 7) == 0);
                s = $urandom_range(0, 1);
                t = $urandom_range(0, 1);
            end else if (m_done) begin
                r = ($urandom_range(0, 9) != 0);
                s = $urandom_range(0, 1);
                t = $urandom_range(0, 1);
            end else begin
                r = ($urandom_range(0, 2999) != 0);
                s = ($urandom_range(0, 3) != 0);
                t = ($urandom_range(0, 29) == 0);
            end
            step(r, s, t, w, d);
            cnt += d;
        end
        check("rand_some_done", (cnt > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
